// File: rtl/prog_loader.sv
// prog_loader: streams a program image into instruction and data memories, then releases the CPU.
// Define LOADER_VERIFY_EN to compile in a checksum-checked readback pass before RUN.
module prog_loader #(
    parameter int IMEM_WORDS = 512,
    parameter int DMEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        start,
    input  logic        stop,
    input  logic [9:0]  i_count,
    input  logic [10:0] d_count,
    input  logic        s_valid,
    input  logic [63:0] s_data,
    output logic        s_ready,
    output logic [63:0] addr_ext,
    output logic        wen_ext,
    output logic        ren_ext,
    output logic [31:0] wdata_ext,
    input  logic [31:0] rdata_ext,
    output logic [63:0] addr_ext_2,
    output logic        wen_ext_2,
    output logic        ren_ext_2,
    output logic [63:0] wdata_ext_2,
    input  logic [63:0] rdata_ext_2,
    output logic        cpu_enable,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [2:0]  o_dbg_state,
    output logic [63:0] o_dbg_csum
);

    localparam logic [10:0] IMEM_MAX = 11'(IMEM_WORDS);
    localparam logic [11:0] DMEM_MAX = 12'(DMEM_WORDS);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD_I   = 3'd1,
        S_LOAD_D   = 3'd2,
`ifdef LOADER_VERIFY_EN
        S_VERIFY_I = 3'd3,
        S_VERIFY_D = 3'd4,
`endif
        S_RUN      = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_next;
    state_t      w_post_load;
    logic [9:0]  r_i_count;
    logic [10:0] r_d_count;
    logic [10:0] r_cnt;
    logic        r_drain;
    logic        r_s_ready;
    logic        r_wen_i;
    logic        r_wen_d;
    logic        r_cpu_enable;
    logic        r_busy;
    logic        r_done;
    logic        r_error;
    logic [63:0] r_addr_i;
    logic [63:0] r_addr_d;
    logic [31:0] r_wdata_i;
    logic [63:0] r_wdata_d;
    logic [63:0] r_csum;
    logic        w_xfer;
    logic        w_cnt_bad;
    logic        w_last_i;
    logic        w_last_d;
    logic        w_drain_set;

    // Stream handshake: a word moves on every rising edge where s_valid && s_ready;
    // s_valid may drop at any time (stall), s_ready depends only on loader state.
    assign w_xfer    = s_valid && r_s_ready;
    assign w_cnt_bad = ({1'b0, i_count} > IMEM_MAX) || ({1'b0, d_count} > DMEM_MAX);
    assign w_last_i  = (r_cnt + 11'd1) == {1'b0, r_i_count};
    assign w_last_d  = (r_cnt + 11'd1) == r_d_count;
    // After the final transfer the loader holds one extra cycle so the last write lands outside RUN.
    assign w_drain_set = !stop && w_xfer &&
                         ((r_state == S_LOAD_I && w_last_i && r_d_count == 11'd0) ||
                          (r_state == S_LOAD_D && w_last_d));

`ifdef LOADER_VERIFY_EN
    logic [63:0] r_rcsum;
    logic        r_ren_i;
    logic        r_ren_d;
    logic        r_pend_i;
    logic        r_pend_d;
    logic        w_vi_done;
    logic        w_vd_done;
    logic        w_match;

    assign w_vi_done = (r_cnt == {1'b0, r_i_count}) && !r_ren_i && !r_pend_i;
    assign w_vd_done = (r_cnt == r_d_count) && !r_ren_d && !r_pend_d;
    assign w_match   = (r_rcsum == r_csum);
    assign ren_ext   = r_ren_i;
    assign ren_ext_2 = r_ren_d;

    always_comb begin
        if (r_i_count != 10'd0)      w_post_load = S_VERIFY_I;
        else if (r_d_count != 11'd0) w_post_load = S_VERIFY_D;
        else                         w_post_load = S_RUN;
    end
`else
    logic w_unused_rdata;

    assign w_unused_rdata = ^{rdata_ext, rdata_ext_2};
    assign ren_ext        = 1'b0;
    assign ren_ext_2      = 1'b0;
    assign w_post_load    = S_RUN;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start && !w_cnt_bad) begin
                    if (i_count != 10'd0)      w_next = S_LOAD_I;
                    else if (d_count != 11'd0) w_next = S_LOAD_D;
                    else                       w_next = S_RUN;
                end
            end
            S_LOAD_I: begin
                if (w_xfer && w_last_i && r_d_count != 11'd0) w_next = S_LOAD_D;
                else if (r_drain)                              w_next = w_post_load;
            end
            S_LOAD_D: begin
                if (r_drain) w_next = w_post_load;
            end
`ifdef LOADER_VERIFY_EN
            S_VERIFY_I: begin
                if (w_vi_done) begin
                    if (r_d_count != 11'd0) w_next = S_VERIFY_D;
                    else                    w_next = w_match ? S_RUN : S_IDLE;
                end
            end
            S_VERIFY_D: begin
                if (w_vd_done) w_next = w_match ? S_RUN : S_IDLE;
            end
`endif
            S_RUN:   w_next = S_RUN;
            default: w_next = S_IDLE;
        endcase
        if (stop) w_next = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            r_state      <= S_IDLE;
            r_i_count    <= '0;
            r_d_count    <= '0;
            r_cnt        <= '0;
            r_drain      <= 1'b0;
            r_s_ready    <= 1'b0;
            r_wen_i      <= 1'b0;
            r_wen_d      <= 1'b0;
            r_cpu_enable <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_addr_i     <= '0;
            r_addr_d     <= '0;
            r_wdata_i    <= '0;
            r_wdata_d    <= '0;
            r_csum       <= '0;
`ifdef LOADER_VERIFY_EN
            r_rcsum      <= '0;
            r_ren_i      <= 1'b0;
            r_ren_d      <= 1'b0;
            r_pend_i     <= 1'b0;
            r_pend_d     <= 1'b0;
`endif
        end else begin
            r_state      <= w_next;
            r_s_ready    <= (w_next == S_LOAD_I || w_next == S_LOAD_D) && !w_drain_set;
            r_cpu_enable <= (w_next == S_RUN);
            r_busy       <= (w_next != S_IDLE) && (w_next != S_RUN);
            r_done       <= (w_next == S_RUN) && (r_state != S_RUN);
            r_drain      <= w_drain_set;
            r_wen_i      <= 1'b0;
            r_wen_d      <= 1'b0;
`ifdef LOADER_VERIFY_EN
            r_ren_i      <= 1'b0;
            r_ren_d      <= 1'b0;
            r_pend_i     <= r_ren_i;
            r_pend_d     <= r_ren_d;
`endif
            if (!stop) begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            if (w_cnt_bad) begin
                                r_error <= 1'b1;
                            end else begin
                                r_error   <= 1'b0;
                                r_i_count <= i_count;
                                r_d_count <= d_count;
                                r_cnt     <= '0;
                                r_csum    <= '0;
`ifdef LOADER_VERIFY_EN
                                r_rcsum   <= '0;
`endif
                            end
                        end
                    end
                    S_LOAD_I: begin
                        if (w_xfer) begin
                            r_wen_i   <= 1'b1;
                            r_addr_i  <= {51'd0, r_cnt, 2'b00};
                            r_wdata_i <= s_data[31:0];
                            r_csum    <= r_csum ^ {32'd0, s_data[31:0]};
                            r_cnt     <= w_last_i ? 11'd0 : r_cnt + 11'd1;
                        end
                    end
                    S_LOAD_D: begin
                        if (w_xfer) begin
                            r_wen_d   <= 1'b1;
                            r_addr_d  <= {50'd0, r_cnt, 3'b000};
                            r_wdata_d <= s_data;
                            r_csum    <= r_csum ^ s_data;
                            r_cnt     <= w_last_d ? 11'd0 : r_cnt + 11'd1;
                        end
                    end
`ifdef LOADER_VERIFY_EN
                    S_VERIFY_I: begin
                        if (r_pend_i) r_rcsum <= r_rcsum ^ {32'd0, rdata_ext};
                        if (w_vi_done) begin
                            r_cnt <= '0;
                            if (r_d_count == 11'd0 && !w_match) r_error <= 1'b1;
                        end else if (r_cnt != {1'b0, r_i_count}) begin
                            r_ren_i  <= 1'b1;
                            r_addr_i <= {51'd0, r_cnt, 2'b00};
                            r_cnt    <= r_cnt + 11'd1;
                        end
                    end
                    S_VERIFY_D: begin
                        if (r_pend_d) r_rcsum <= r_rcsum ^ rdata_ext_2;
                        if (w_vd_done) begin
                            r_cnt <= '0;
                            if (!w_match) r_error <= 1'b1;
                        end else if (r_cnt != r_d_count) begin
                            r_ren_d  <= 1'b1;
                            r_addr_d <= {50'd0, r_cnt, 3'b000};
                            r_cnt    <= r_cnt + 11'd1;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    assign s_ready     = r_s_ready;
    assign addr_ext    = r_addr_i;
    assign wen_ext     = r_wen_i;
    assign wdata_ext   = r_wdata_i;
    assign addr_ext_2  = r_addr_d;
    assign wen_ext_2   = r_wen_d;
    assign wdata_ext_2 = r_wdata_d;
    assign cpu_enable  = r_cpu_enable;
    assign busy        = r_busy;
    assign done        = r_done;
    assign error       = r_error;
    assign o_dbg_state = r_state;
    assign o_dbg_csum  = r_csum;

endmodule
